// File: rtl/wb_slave_mem_responder.sv
// Purpose : Wishbone B4 pipelined slave. Queues requests in order, inserts a
//           programmable wait-state delay, then answers from an internal word memory.
// Latency : ACK/ERR in cycle N+1+WAIT_STATES_IN for a request accepted in cycle N
//           on an empty queue; one response per cycle sustained with zero wait states.
// Backpressure: WB_STALL_OUT is high exactly while the request queue is full.
// Ports   : CLK, RST_ASYNC_N     clock and asynchronous active-low reset
//           WAIT_STATES_IN       extra cycles before each response, sampled at pop
//           WB_CYC/STB/WE/SEL/ADR/DAT_WR_IN   master-to-slave request
//           WB_STALL/ACK/ERR/DAT_RD_OUT       slave-to-master response
module wb_slave_mem_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          MEM_WORDS  = 1024,
  parameter int          FIFO_DEPTH = 4,
  parameter int          WAIT_W     = 4
) (
  input  logic              CLK,
  input  logic              RST_ASYNC_N,
  input  logic [WAIT_W-1:0] WAIT_STATES_IN,
  input  logic              WB_CYC_IN,
  input  logic              WB_STB_IN,
  input  logic              WB_WE_IN,
  input  logic [3:0]        WB_SEL_IN,
  input  logic [31:0]       WB_ADR_IN,
  input  logic [31:0]       WB_DAT_WR_IN,
  output logic              WB_STALL_OUT,
  output logic              WB_ACK_OUT,
  output logic              WB_ERR_OUT,
  output logic [31:0]       WB_DAT_RD_OUT
);

  localparam int          IDX_W     = $clog2(MEM_WORDS);
  localparam int          PTR_W     = $clog2(FIFO_DEPTH);
  localparam int          CNT_W     = PTR_W + 1;
  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);

  // Address is decoded once at acceptance; the queue stores the word index
  // and the range verdict instead of the raw byte address.
  typedef struct packed {
    logic             we;
    logic             in_range;
    logic [3:0]       sel;
    logic [IDX_W-1:0] idx;
    logic [31:0]      dat;
  } req_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic [31:0] offset;
  req_t        bus_req;

  always_comb begin
    offset           = WB_ADR_IN - BASE_ADDR;
    bus_req.we       = WB_WE_IN;
    // Unsigned compare: addresses below BASE_ADDR wrap to huge offsets.
    bus_req.in_range = (offset < MEM_BYTES);
    bus_req.sel      = WB_SEL_IN;
    bus_req.idx      = offset[IDX_W+1:2];
    bus_req.dat      = WB_DAT_WR_IN;
  end

  // ---------------------------------------------------------------------------
  // Request queue
  // ---------------------------------------------------------------------------
  req_t             fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic fifo_empty;
  logic push;
  logic pop;
  logic avail;
  logic bypass;
  logic fifo_wr;
  logic fifo_rd;
  req_t head;

  assign WB_STALL_OUT = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty   = (count_q == '0);
  assign push         = WB_CYC_IN & WB_STB_IN & ~WB_STALL_OUT;
  assign avail        = ~fifo_empty | push;

  // With an empty queue the engine takes the incoming request directly, so a
  // zero-wait request is answered in the very next cycle. A bypassed request
  // never occupies a queue slot.
  assign bypass  = pop & fifo_empty;
  assign fifo_wr = push & ~bypass;
  assign fifo_rd = pop & ~fifo_empty;
  assign head    = fifo_empty ? bus_req : fifo_mem_q[rd_ptr_q];

  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (!WB_CYC_IN) begin
      // Bus cycle abort flushes everything still queued.
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (fifo_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (fifo_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CNT_W'(fifo_wr) - CNT_W'(fifo_rd);
    end
  end

  always_ff @(posedge CLK) begin
    if (fifo_wr) fifo_mem_q[wr_ptr_q] <= bus_req;
  end

  // ---------------------------------------------------------------------------
  // Response engine
  // ---------------------------------------------------------------------------
  // ST_RESP is the cycle in which ACK/ERR is visible; the response registers
  // and the memory write are loaded on the edge that enters ST_RESP.
  state_t            state_q;
  state_t            state_d;
  logic [WAIT_W-1:0] wcnt_q;
  logic [WAIT_W-1:0] wcnt_d;
  req_t              cur_q;
  req_t              resp_req;
  logic              issue;
  logic              load_cur;
  logic              go_wait;

  assign go_wait = (WAIT_STATES_IN != '0);

  // State register
  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) state_q <= ST_IDLE;
    else              state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!WB_CYC_IN) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_RESP: begin
          if (avail) state_d = go_wait ? ST_WAIT : ST_RESP;
          else       state_d = ST_IDLE;
        end
        ST_WAIT: begin
          if (wcnt_q <= WAIT_W'(1)) state_d = ST_RESP;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Engine control outputs
  always_comb begin
    pop      = 1'b0;
    issue    = 1'b0;
    load_cur = 1'b0;
    wcnt_d   = wcnt_q;
    resp_req = cur_q;
    if (!WB_CYC_IN) begin
      wcnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_RESP: begin
          if (avail) begin
            pop = 1'b1;
            if (go_wait) begin
              load_cur = 1'b1;
              wcnt_d   = WAIT_STATES_IN;
            end else begin
              issue    = 1'b1;
              resp_req = head;
            end
          end
        end
        ST_WAIT: begin
          wcnt_d = wcnt_q - 1'b1;
          if (wcnt_q <= WAIT_W'(1)) issue = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Memory and response registers
  // ---------------------------------------------------------------------------
  logic [31:0] mem_q [MEM_WORDS];
  logic        mem_we;
  logic        ack_q;
  logic        ack_d;
  logic        err_q;
  logic        err_d;
  logic [31:0] dat_q;
  logic [31:0] dat_d;

  // Reads sample the array combinationally at the issuing edge, so every
  // write issued on an earlier edge is already visible (queue-order RAW).
  always_comb begin
    ack_d  = issue & resp_req.in_range;
    err_d  = issue & ~resp_req.in_range;
    mem_we = issue & resp_req.in_range & resp_req.we;
    dat_d  = (issue & resp_req.in_range & ~resp_req.we) ? mem_q[resp_req.idx] : '0;
  end

  always_ff @(posedge CLK) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (resp_req.sel[b]) mem_q[resp_req.idx][8*b +: 8] <= resp_req.dat[8*b +: 8];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      wcnt_q <= '0;
      cur_q  <= '0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      dat_q  <= '0;
    end else begin
      wcnt_q <= wcnt_d;
      if (load_cur) cur_q <= head;
      ack_q <= ack_d;
      err_q <= err_d;
      dat_q <= dat_d;
    end
  end

  // Gating by CYC makes an abort silence the bus in the same cycle.
  assign WB_ACK_OUT    = ack_q & WB_CYC_IN;
  assign WB_ERR_OUT    = err_q & WB_CYC_IN;
  assign WB_DAT_RD_OUT = WB_CYC_IN ? dat_q : '0;

endmodule

// File: tb/tb_wb_slave_mem_responder.sv
// Purpose : directed self-checking bench for wb_slave_mem_responder.
// Latency : responses are logged with the cycle number they appear in and
//           compared against the accept cycle of the matching request.
// Backpressure: the send task holds STB until STALL is seen low.
module tb_wb_slave_mem_responder;

  // Memory sits at 0x1000 so that both out-of-range sides can be exercised;
  // in-range addresses below are written as B + offset.
  localparam logic [31:0] B = 32'h0000_1000;

  logic        CLK = 1'b0;
  logic        RST_ASYNC_N;
  logic [3:0]  WAIT_STATES_IN;
  logic        WB_CYC_IN;
  logic        WB_STB_IN;
  logic        WB_WE_IN;
  logic [3:0]  WB_SEL_IN;
  logic [31:0] WB_ADR_IN;
  logic [31:0] WB_DAT_WR_IN;
  logic        WB_STALL_OUT;
  logic        WB_ACK_OUT;
  logic        WB_ERR_OUT;
  logic [31:0] WB_DAT_RD_OUT;

  always #5 CLK = ~CLK;

  wb_slave_mem_responder #(
    .BASE_ADDR (B),
    .MEM_WORDS (1024),
    .FIFO_DEPTH(4),
    .WAIT_W    (4)
  ) dut (
    .CLK           (CLK),
    .RST_ASYNC_N   (RST_ASYNC_N),
    .WAIT_STATES_IN(WAIT_STATES_IN),
    .WB_CYC_IN     (WB_CYC_IN),
    .WB_STB_IN     (WB_STB_IN),
    .WB_WE_IN      (WB_WE_IN),
    .WB_SEL_IN     (WB_SEL_IN),
    .WB_ADR_IN     (WB_ADR_IN),
    .WB_DAT_WR_IN  (WB_DAT_WR_IN),
    .WB_STALL_OUT  (WB_STALL_OUT),
    .WB_ACK_OUT    (WB_ACK_OUT),
    .WB_ERR_OUT    (WB_ERR_OUT),
    .WB_DAT_RD_OUT (WB_DAT_RD_OUT)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Cycle counter and response log (written only by these processes).
  typedef struct {
    logic        ack;
    logic        err;
    logic [31:0] dat;
    int          cyc;
  } resp_t;

  int    cyc_n     = 0;
  resp_t resp_q[$];
  resp_t r_tmp;
  int    dat_leak  = 0;
  int    both_cnt  = 0;

  always @(posedge CLK) cyc_n <= cyc_n + 1;

  always @(negedge CLK) begin
    if (WB_ACK_OUT || WB_ERR_OUT) begin
      r_tmp.ack = WB_ACK_OUT;
      r_tmp.err = WB_ERR_OUT;
      r_tmp.dat = WB_DAT_RD_OUT;
      r_tmp.cyc = cyc_n;
      resp_q.push_back(r_tmp);
    end
    if (!WB_ACK_OUT && WB_DAT_RD_OUT != 32'h0) dat_leak++;
    if (WB_ACK_OUT && WB_ERR_OUT) both_cnt++;
  end

  int acc_cyc[$];
  int base_r = 0;

  task automatic clr();
    acc_cyc.delete();
    base_r = resp_q.size();
  endtask

  function automatic int nresp();
    return resp_q.size() - base_r;
  endfunction

  // Present one request (called at posedge+1) and hold it until accepted.
  task automatic send(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output int stalls);
    WB_CYC_IN    = 1'b1;
    WB_STB_IN    = 1'b1;
    WB_WE_IN     = we;
    WB_ADR_IN    = adr;
    WB_DAT_WR_IN = dat;
    WB_SEL_IN    = sel;
    stalls       = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (!WB_STALL_OUT) begin
        acc_cyc.push_back(cyc_n);
        @(posedge CLK);
        #1;
        return;
      end
      stalls++;
      @(posedge CLK);
      #1;
    end
    chk("accept_timeout", 32'(stalls), 32'd0);
    WB_STB_IN = 1'b0;
  endtask

  task automatic idle(input int n);
    WB_STB_IN = 1'b0;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Check response k of the current test against its request's accept cycle.
  task automatic chk_resp(input string tag, input int k, input logic err,
                          input logic [31:0] dat, input int lat, input bit cd);
    if ((base_r + k) < resp_q.size() && k < acc_cyc.size()) begin
      chk({tag, "_ack"}, 32'(resp_q[base_r+k].ack), 32'(!err));
      chk({tag, "_err"}, 32'(resp_q[base_r+k].err), 32'(err));
      chk({tag, "_lat"}, 32'(resp_q[base_r+k].cyc - acc_cyc[k]), 32'(lat));
      if (cd) chk({tag, "_dat"}, resp_q[base_r+k].dat, dat);
    end else begin
      chk({tag, "_missing"}, 32'(nresp()), 32'(k + 1));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  int st;
  int st_bp[6];

  initial begin
    RST_ASYNC_N    = 1'b0;
    WAIT_STATES_IN = 4'd0;
    WB_CYC_IN      = 1'b0;
    WB_STB_IN      = 1'b0;
    WB_WE_IN       = 1'b0;
    WB_SEL_IN      = 4'h0;
    WB_ADR_IN      = 32'h0;
    WB_DAT_WR_IN   = 32'h0;

    // Reset state
    #12;
    chk("rst_ack",   32'(WB_ACK_OUT),   32'd0);
    chk("rst_err",   32'(WB_ERR_OUT),   32'd0);
    chk("rst_dat",   WB_DAT_RD_OUT,     32'd0);
    chk("rst_stall", 32'(WB_STALL_OUT), 32'd0);
    @(posedge CLK); #1;
    RST_ASYNC_N = 1'b1;
    @(posedge CLK); #1;
    WB_CYC_IN = 1'b1;
    idle(2);

    // Single write then read, zero wait
    clr();
    send(1'b1, B + 32'h10, 32'hDEAD_BEEF, 4'hF, st);
    idle(3);
    send(1'b0, B + 32'h10, 32'h0, 4'hF, st);
    idle(3);
    chk("t1_count", 32'(nresp()), 32'd2);
    chk_resp("t1_wr", 0, 1'b0, 32'h0, 1, 1'b0);
    chk_resp("t1_rd", 1, 1'b0, 32'hDEAD_BEEF, 1, 1'b1);

    // Byte enables, SEL=0 write, back-to-back at one response per cycle
    clr();
    send(1'b1, B + 32'h0, 32'hFFFF_FFFF, 4'hF, st);
    send(1'b1, B + 32'h0, 32'h1122_3344, 4'h5, st);
    send(1'b1, B + 32'h0, 32'hAAAA_AAAA, 4'h0, st);
    send(1'b0, B + 32'h0, 32'h0, 4'hF, st);
    idle(4);
    chk("t2_count", 32'(nresp()), 32'd4);
    chk_resp("t2_wr_full", 0, 1'b0, 32'h0, 1, 1'b0);
    chk_resp("t2_wr_sel5", 1, 1'b0, 32'h0, 1, 1'b0);
    chk_resp("t2_wr_sel0", 2, 1'b0, 32'h0, 1, 1'b0);
    chk_resp("t2_rd",      3, 1'b0, 32'hFF22_FF44, 1, 1'b1);

    // Wait states: ACK 4 cycles after accept, nothing before
    WAIT_STATES_IN = 4'd3;
    clr();
    send(1'b0, B + 32'h10, 32'h0, 4'hF, st);
    idle(8);
    chk("t3_count", 32'(nresp()), 32'd1);
    chk_resp("t3_rd", 0, 1'b0, 32'hDEAD_BEEF, 4, 1'b1);

    // Out of range: 0x2000 above, 0x0FFC below (aliases last word if unchecked)
    WAIT_STATES_IN = 4'd0;
    clr();
    send(1'b1, B + 32'hFFC, 32'hCAFE_F00D, 4'hF, st);
    send(1'b0, 32'h0000_2000, 32'h0, 4'hF, st);
    send(1'b1, 32'h0000_0FFC, 32'h1234_5678, 4'hF, st);
    send(1'b0, B + 32'hFFC, 32'h0, 4'hF, st);
    send(1'b0, B + 32'h0, 32'h0, 4'hF, st);
    idle(4);
    chk("t4_count", 32'(nresp()), 32'd5);
    chk_resp("t4_wr_last", 0, 1'b0, 32'h0, 1, 1'b0);
    chk_resp("t4_rd_high", 1, 1'b1, 32'h0, 1, 1'b1);
    chk_resp("t4_wr_low",  2, 1'b1, 32'h0, 1, 1'b0);
    chk_resp("t4_rd_last", 3, 1'b0, 32'hCAFE_F00D, 1, 1'b1);
    chk_resp("t4_rd_w0",   4, 1'b0, 32'hFF22_FF44, 1, 1'b1);

    // Back-pressure, WAIT=7. The first request goes straight into the engine,
    // so the 4-entry queue is full after the fifth accept; the sixth stalls
    // until the first response cycle pops the queue head (4 stalled cycles).
    // Responses land every 8 cycles from the first accept.
    WAIT_STATES_IN = 4'd7;
    clr();
    send(1'b1, B + 32'h20, 32'hA1A1_A1A1, 4'hF, st_bp[0]);
    send(1'b1, B + 32'h24, 32'hB2B2_B2B2, 4'hF, st_bp[1]);
    send(1'b0, B + 32'h20, 32'h0,         4'hF, st_bp[2]);
    send(1'b1, B + 32'h20, 32'hC3C3_C3C3, 4'hF, st_bp[3]);
    send(1'b0, B + 32'h20, 32'h0,         4'hF, st_bp[4]);
    send(1'b0, B + 32'h24, 32'h0,         4'hF, st_bp[5]);
    idle(60);
    chk("t5_stall_5th", 32'(st_bp[4]), 32'd0);
    chk("t5_stall_6th", 32'(st_bp[5]), 32'd4);
    if (acc_cyc.size() == 6) chk("t5_acc6_delay", 32'(acc_cyc[5] - acc_cyc[0]), 32'd9);
    chk("t5_count", 32'(nresp()), 32'd6);
    chk_resp("t5_r0", 0, 1'b0, 32'h0,         8,  1'b0);
    chk_resp("t5_r1", 1, 1'b0, 32'h0,         15, 1'b0);
    chk_resp("t5_r2", 2, 1'b0, 32'hA1A1_A1A1, 22, 1'b1);
    chk_resp("t5_r3", 3, 1'b0, 32'h0,         29, 1'b0);
    chk_resp("t5_r4", 4, 1'b0, 32'hC3C3_C3C3, 36, 1'b1);
    chk_resp("t5_r5", 5, 1'b0, 32'hB2B2_B2B2, 39, 1'b1);

    // Abort: preload, queue 3 writes with WAIT=5, drop CYC before any response
    WAIT_STATES_IN = 4'd0;
    send(1'b1, B + 32'h80, 32'hA0A0_A0A0, 4'hF, st);
    send(1'b1, B + 32'h84, 32'hB0B0_B0B0, 4'hF, st);
    send(1'b1, B + 32'h88, 32'hC0C0_C0C0, 4'hF, st);
    idle(3);
    WAIT_STATES_IN = 4'd5;
    clr();
    send(1'b1, B + 32'h80, 32'h1111_1111, 4'hF, st);
    send(1'b1, B + 32'h84, 32'h2222_2222, 4'hF, st);
    send(1'b1, B + 32'h88, 32'h3333_3333, 4'hF, st);
    idle(2);
    WB_CYC_IN = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    WB_CYC_IN = 1'b1;
    idle(12);
    chk("t6_no_resp", 32'(nresp()), 32'd0);
    WAIT_STATES_IN = 4'd0;
    clr();
    send(1'b0, B + 32'h80, 32'h0, 4'hF, st);
    send(1'b0, B + 32'h84, 32'h0, 4'hF, st);
    send(1'b0, B + 32'h88, 32'h0, 4'hF, st);
    idle(4);
    chk_resp("t6_rd80", 0, 1'b0, 32'hA0A0_A0A0, 1, 1'b1);
    chk_resp("t6_rd84", 1, 1'b0, 32'hB0B0_B0B0, 1, 1'b1);
    chk_resp("t6_rd88", 2, 1'b0, 32'hC0C0_C0C0, 1, 1'b1);

    // Async reset mid-WAIT with a full queue
    WAIT_STATES_IN = 4'd5;
    clr();
    send(1'b1, B + 32'h80, 32'h4444_4444, 4'hF, st);
    send(1'b1, B + 32'h84, 32'h5555_5555, 4'hF, st);
    send(1'b1, B + 32'h88, 32'h6666_6666, 4'hF, st);
    send(1'b1, B + 32'h8C, 32'h7777_7777, 4'hF, st);
    send(1'b1, B + 32'h90, 32'h8888_8888, 4'hF, st);
    WB_STB_IN = 1'b0;
    chk("t7_full_before_rst", 32'(WB_STALL_OUT), 32'd1);
    #2;
    RST_ASYNC_N = 1'b0;
    #1;
    chk("t7_rst_stall", 32'(WB_STALL_OUT), 32'd0);
    chk("t7_rst_ack",   32'(WB_ACK_OUT),   32'd0);
    chk("t7_rst_err",   32'(WB_ERR_OUT),   32'd0);
    chk("t7_rst_dat",   WB_DAT_RD_OUT,     32'd0);
    @(posedge CLK); #1;
    RST_ASYNC_N = 1'b1;
    chk("t7_stall_after", 32'(WB_STALL_OUT), 32'd0);
    idle(12);
    chk("t7_no_resp", 32'(nresp()), 32'd0);
    WAIT_STATES_IN = 4'd0;
    clr();
    send(1'b0, B + 32'h80, 32'h0, 4'hF, st);
    send(1'b0, B + 32'h84, 32'h0, 4'hF, st);
    send(1'b0, B + 32'h88, 32'h0, 4'hF, st);
    idle(4);
    chk_resp("t7_rd80", 0, 1'b0, 32'hA0A0_A0A0, 1, 1'b1);
    chk_resp("t7_rd84", 1, 1'b0, 32'hB0B0_B0B0, 1, 1'b1);
    chk_resp("t7_rd88", 2, 1'b0, 32'hC0C0_C0C0, 1, 1'b1);

    // Reset asserted while ACK is high clears the outputs at once
    WB_CYC_IN    = 1'b1;
    WB_STB_IN    = 1'b1;
    WB_WE_IN     = 1'b0;
    WB_ADR_IN    = B + 32'h10;
    WB_SEL_IN    = 4'hF;
    @(posedge CLK); #1;
    WB_STB_IN = 1'b0;
    #2;
    chk("t8_ack_before", 32'(WB_ACK_OUT), 32'd1);
    chk("t8_dat_before", WB_DAT_RD_OUT,   32'hDEAD_BEEF);
    RST_ASYNC_N = 1'b0;
    #1;
    chk("t8_ack_async", 32'(WB_ACK_OUT), 32'd0);
    chk("t8_dat_async", WB_DAT_RD_OUT,   32'd0);
    @(posedge CLK); #1;
    RST_ASYNC_N = 1'b1;
    idle(2);

    // Global protocol properties over the whole run
    chk("dat_zero_without_ack", 32'(dat_leak), 32'd0);
    chk("ack_and_err_together", 32'(both_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
